// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (IF) and load/store (DM) ports.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_dm_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_lat_cnt;
  logic [3:0]        r_starve;
  logic              r_owner_dm;
  logic              r_is_write;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_if_win;
  logic              w_dm_win;

  always_comb begin
    w_state_nxt = r_state;
    w_if_win    = 1'b0;
    w_dm_win    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if_rvalid   = 1'b0;
    dm_rvalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!reset) begin
          // DM has priority unless IF is alone or has lost STARVE_MAX times in a row
          w_if_win = if_req && (!dm_req || (r_starve == 4'(STARVE_MAX)));
          w_dm_win = dm_req && !w_if_win;
        end
        if (w_if_win) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
        end else if (w_dm_win) begin
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
        end
        if (w_if_win || w_dm_win) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if_rvalid   = !r_owner_dm;
        dm_rvalid   = r_owner_dm;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign if_gnt   = w_if_win;
  assign dm_gnt   = w_dm_win;
  assign busy     = (r_state != S_IDLE);
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= '0;
      r_starve   <= '0;
      r_owner_dm <= 1'b0;
      r_is_write <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_if_win || w_dm_win) begin
            r_owner_dm <= w_dm_win;
            r_is_write <= w_dm_win && dm_we;
            r_lat_cnt  <= 4'(MEM_LAT - 1);
          end
          if (w_if_win) begin
            r_starve <= '0;
          end else if (if_req && w_dm_win && (r_starve != 4'(STARVE_MAX))) begin
            r_starve <= r_starve + 4'd1;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_owner_dm) r_dm_rdata <= r_is_write ? '0 : mem_rdata;
            else            r_if_rdata <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic w_any_req;
  assign w_any_req = if_req || dm_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_cnt    <= '0;
      perf_dm_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_if_win) perf_if_cnt <= perf_if_cnt + 32'd1;
      if (w_dm_win) perf_dm_cnt <= perf_dm_cnt + 32'd1;
      if (w_any_req && !(w_if_win || w_dm_win)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
